conv3x3_window_gen: RTL and testbench
=====================================

Name: conv3x3_window_gen

Overview:
Producer side of the 3x3 convolution datapath: converts a raster-order pixel stream into 3x3 windows for the inner-dot engine.
- Two on-chip line buffers plus a 3x3 register window ("valid" convolution, no padding).
- Emits one window per accepted pixel once two full rows and two columns are available.
- Its win0..win8 / win_vld outputs connect directly to the engine's data0..data8 / in_vld inputs.

Parameters:
IMG_W, 8, pixels per row (>=3); line-buffer depth.
IMG_H, 8, rows per frame (>=3).
DATA_W, 8, signed pixel width (engine requires 8).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
pix_vld  input  1  pixel strobe; one pixel accepted per cycle it is high.
pix_sof  input  1  start-of-frame; qualified by pix_vld; marks the pixel as (row 0, col 0).
pix_in  input  DATA_W  signed pixel, raster order.
win0..win8  output  DATA_W each  signed window; win[3*i+j] = pixel(r-2+i, c-2+j); win0 is top-left, win8 is the newest pixel.
win_vld  output  1  window valid (one-cycle strobe per window).
frame_done  output  1  one-cycle pulse; last pixel of frame accepted.

Behaviour:
Reset:
- Async on rst high: win0..win8=0, win_vld=0, frame_done=0, row=0, col=0.
- Line-buffer contents are don't-care; no window is emitted until refilled.

Counters:
- col 0..IMG_W-1 and row 0..IMG_H-1 advance only on pix_vld.
- col wraps to 0 and increments row.
- At (IMG_H-1, IMG_W-1), both wrap to 0; the next pixel is the first pixel of the next frame.

pix_sof:
- pix_vld&pix_sof forces this pixel to be (0,0) regardless of the counters; counters resync and the partial frame is discarded.
- pix_sof without pix_vld is ignored.
- pix_sof at (0,0) is harmless.

Window update (accepted pixel only):
- Shift the window left one column.
- New right column = {linebuf1[col], linebuf0[col], pix_in}, top to bottom.
- Write linebuf1[col]<=linebuf0[col] and linebuf0[col]<=pix_in.
- The window shift happens every accepted pixel, including col<2 and row<2.

Valid:
- win_vld=1 in the cycle after accepting a pixel with row>=2 and col>=2; otherwise 0.
- Latency is 1 cycle, pixel to window.
- (IMG_H-2)*(IMG_W-2) windows per frame.
- Windows never straddle a row wrap, because col<2 suppresses them.

Stalls:
- pix_vld low: no state change; win0..win8 hold their last values; win_vld=0.
- Arbitrary gaps are allowed, and throughput is 1 window/cycle during full-rate streaming.

frame_done:
- Registered; asserted the cycle after the (IMG_H-1, IMG_W-1) pixel is accepted.
- Coincides with that pixel's win_vld.

Width:
- Pure data movement, no arithmetic; signed values pass bit-exact.

Reset mid-frame:
- Outputs and counters clear immediately (asynchronously).
- The stream must restart at (0,0).

Implementation:
- No backpressure: the downstream engine accepts every cycle.
- Line buffers may be registers or inferred RAM with a single read/write per cycle.
- Either way, read-before-write at the same address within the cycle is required.

Test Plan:
1. IMG_W=5, IMG_H=4; pixels p(r,c)=r*5+c streamed back-to-back.
   - First win_vld is the cycle after pixel 12, with win = 0,1,2,5,6,7,10,11,12.
   - Exactly 6 strobes.
   - Last window (after pixel 19) = 7,8,9,12,13,14,17,18,19, with frame_done high in the same cycle.
2. Same frame with 0–3 random idle cycles between pixels: identical 6 windows in order; win_vld never high during gaps; outputs hold between strobes.
3. Two frames back-to-back without gaps, second frame pixels = p+100: the first window of frame 2 is 100,101,102,105,106,107,110,111,112; no window mixes frame-1 data.
4. pix_sof asserted at pixel (2,1) of a frame, then a full frame streamed: no win_vld from the aborted frame after sof; the new frame yields exactly 6 correct windows.
5. Signed data: pixels alternating -128 and 127 → windows match the raster model bit-exact, with no sign corruption.
6. rst pulsed (asynchronously, mid-cycle) after pixel 13 of frame 1: outputs go to 0 immediately; the restarted frame produces exactly 6 correct windows and one frame_done.

Source files
------------

// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen
// Turns a raster-order pixel stream into 3x3 "valid" convolution windows.
// Two line buffers hold the previous two rows; a 3x3 register window shifts
// left on every accepted pixel and takes {linebuf1[col], linebuf0[col], pix_in}
// as its new right column.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   pix_vld      pixel strobe, one pixel accepted per high cycle
//   pix_sof      start-of-frame, qualified by pix_vld; forces pixel to (0,0)
//   pix_in       signed pixel, raster order
//   win0..win8   window, win[3*i+j] = pixel(r-2+i, c-2+j); win8 is newest
//   win_vld      one-cycle strobe per complete window
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted
module conv3x3_window_gen #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_vld,
    input  logic                     pix_sof,
    input  logic signed [DATA_W-1:0] pix_in,
    output logic signed [DATA_W-1:0] win0,
    output logic signed [DATA_W-1:0] win1,
    output logic signed [DATA_W-1:0] win2,
    output logic signed [DATA_W-1:0] win3,
    output logic signed [DATA_W-1:0] win4,
    output logic signed [DATA_W-1:0] win5,
    output logic signed [DATA_W-1:0] win6,
    output logic signed [DATA_W-1:0] win7,
    output logic signed [DATA_W-1:0] win8,
    output logic                     win_vld,
    output logic                     frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;

    logic signed [DATA_W-1:0] lb0 [IMG_W];
    logic signed [DATA_W-1:0] lb1 [IMG_W];
    logic signed [DATA_W-1:0] win_r [9];

    // A start-of-frame pixel is (0,0) whatever the counters say, so all
    // position-dependent logic uses this resynchronised position.
    always_comb begin
        cur_col = col;
        cur_row = row;
        if (pix_vld && pix_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                win_r[k] <= '0;
            end
            win_vld    <= 1'b0;
            frame_done <= 1'b0;
            col        <= '0;
            row        <= '0;
        end else begin
            win_vld    <= 1'b0;
            frame_done <= 1'b0;
            if (pix_vld) begin
                win_r[0] <= win_r[1];
                win_r[1] <= win_r[2];
                win_r[2] <= lb1[cur_col];
                win_r[3] <= win_r[4];
                win_r[4] <= win_r[5];
                win_r[5] <= lb0[cur_col];
                win_r[6] <= win_r[7];
                win_r[7] <= win_r[8];
                win_r[8] <= pix_in;

                // col < 2 keeps windows from straddling a row wrap.
                win_vld    <= (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
                frame_done <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);

                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
                end else begin
                    col <= cur_col + COL_W'(1);
                    row <= cur_row;
                end
            end
        end
    end

    // Line buffers need no reset: rows 0 and 1 of every frame refill them
    // before any window is flagged valid. Nonblocking writes give the
    // read-before-write behaviour the window shift relies on.
    always_ff @(posedge clk) begin
        if (pix_vld) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= pix_in;
        end
    end

    assign win0 = win_r[0];
    assign win1 = win_r[1];
    assign win2 = win_r[2];
    assign win3 = win_r[3];
    assign win4 = win_r[4];
    assign win5 = win_r[5];
    assign win6 = win_r[6];
    assign win7 = win_r[7];
    assign win8 = win_r[8];

endmodule

// File: tb/tb_conv3x3_window_gen.sv
module tb_conv3x3_window_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_vld = 1'b0;
    logic pix_sof = 1'b0;
    logic signed [DW-1:0] pix_in = '0;
    logic signed [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic win_vld, frame_done;

    conv3x3_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_in(pix_in),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
        .win5(win5), .win6(win6), .win7(win7), .win8(win8),
        .win_vld(win_vld), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: whole-frame pixel memory indexed by raster position.
    int          m_idx;
    logic [7:0]  m_mem [N];
    logic [71:0] m_last;
    bit          m_held;
    int          vld_seen;
    int          fd_seen;

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  p;
        logic        ev;
        logic        efd;
        logic [71:0] ew;
    } vec_t;

    vec_t tbl [N];

    function automatic logic [71:0] dut_win();
        return {win0, win1, win2, win3, win4, win5, win6, win7, win8};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of input, predict from the model, clock, compare.
    task automatic cyc(input logic v, input logic s, input logic [7:0] p, input string tag);
        logic        ev;
        logic        efd;
        logic [71:0] ew;
        bit          chk_w;
        int          r;
        int          c;
        pix_vld = v;
        pix_sof = s;
        pix_in  = p;
        ev    = 1'b0;
        efd   = 1'b0;
        ew    = m_last;
        chk_w = m_held && !v;
        if (v) begin
            if (s) m_idx = 0;
            r = m_idx / W;
            c = m_idx % W;
            m_mem[m_idx] = p;
            efd = (m_idx == N - 1);
            if (r >= 2 && c >= 2) begin
                ev = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[(8 - (3 * i + j)) * 8 +: 8] = m_mem[(r - 2 + i) * W + (c - 2 + j)];
                m_last = ew;
                m_held = 1'b1;
                chk_w  = 1'b1;
            end else begin
                m_held = 1'b0;
            end
            m_idx = (m_idx + 1) % N;
        end
        @(posedge clk);
        #1;
        pix_vld = 1'b0;
        pix_sof = 1'b0;
        check_bit({tag, " win_vld"}, win_vld, ev);
        check_bit({tag, " frame_done"}, frame_done, efd);
        if (chk_w) check_win({tag, " window"}, dut_win(), ew);
        if (win_vld) vld_seen++;
        if (frame_done) fd_seen++;
    endtask

    task automatic gaps(input int n, input string tag);
        for (int g = 0; g < n; g++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table for test 1: p(r,c) = r*5+c streamed back-to-back.
        for (int k = 0; k < N; k++) begin
            int r;
            int c;
            r = k / W;
            c = k % W;
            tbl[k].v   = 1'b1;
            tbl[k].s   = (k == 0);
            tbl[k].p   = 8'(k);
            tbl[k].ev  = (r >= 2 && c >= 2);
            tbl[k].efd = (k == N - 1);
            tbl[k].ew  = '0;
            if (r >= 2 && c >= 2)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        tbl[k].ew[(8 - (3 * i + j)) * 8 +: 8] = 8'((r - 2 + i) * W + (c - 2 + j));
        end

        m_idx = 0; m_last = '0; m_held = 1'b1; vld_seen = 0; fd_seen = 0;

        #22;
        check_win("reset window", dut_win(), 72'h0);
        check_bit("reset win_vld", win_vld, 1'b0);
        check_bit("reset frame_done", frame_done, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: table-driven.
        for (int k = 0; k < N; k++) begin
            pix_vld = tbl[k].v;
            pix_sof = tbl[k].s;
            pix_in  = tbl[k].p;
            @(posedge clk);
            #1;
            pix_vld = 1'b0;
            pix_sof = 1'b0;
            check_bit("t1 win_vld", win_vld, tbl[k].ev);
            check_bit("t1 frame_done", frame_done, tbl[k].efd);
            if (tbl[k].ev) check_win("t1 window", dut_win(), tbl[k].ew);
            if (win_vld) vld_seen++;
            if (k == 12)
                check_win("t1 first window", dut_win(),
                          {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
            if (k == N - 1)
                check_win("t1 last window", dut_win(),
                          {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19});
        end
        check_int("t1 strobe count", vld_seen, 6);
        m_idx = 0; m_last = tbl[N - 1].ew; m_held = 1'b1;

        // Test 2: same frame with random idle gaps; outputs must hold.
        vld_seen = 0;
        for (int k = 0; k < N; k++) begin
            cyc(1'b1, k == 0, 8'(k), "t2");
            gaps($urandom_range(0, 3), "t2 gap");
        end
        check_int("t2 strobe count", vld_seen, 6);

        // Test 3: two frames back-to-back, second offset by 100.
        vld_seen = 0;
        for (int k = 0; k < N; k++) cyc(1'b1, k == 0, 8'(k), "t3 f1");
        for (int k = 0; k < N; k++) begin
            cyc(1'b1, 1'b0, 8'(k + 100), "t3 f2");
            if (k == 12)
                check_win("t3 f2 first window", dut_win(),
                          {8'd100, 8'd101, 8'd102, 8'd105, 8'd106, 8'd107, 8'd110, 8'd111, 8'd112});
        end
        check_int("t3 strobe count", vld_seen, 12);

        // Test 4: abort at (2,1) with sof, then a full frame.
        for (int k = 0; k < 11; k++) cyc(1'b1, k == 0, 8'(k + 50), "t4 abort");
        vld_seen = 0; fd_seen = 0;
        for (int k = 0; k < N; k++) cyc(1'b1, k == 0, 8'(k + 20), "t4 new");
        check_int("t4 strobe count", vld_seen, 6);
        check_int("t4 frame_done count", fd_seen, 1);

        // Test 5: signed extremes, then random signed frames with gaps and stray sof.
        for (int k = 0; k < N; k++) cyc(1'b1, k == 0, (k % 2) ? 8'h7f : 8'h80, "t5 alt");
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < N; k++) begin
                cyc(1'b1, (k == 0) || ($urandom_range(0, 40) == 0), 8'($urandom), "t5 rand");
                gaps($urandom_range(0, 2), "t5 gap");
            end

        // Test 6: async reset mid-cycle after pixel 13.
        for (int k = 0; k < N; k++) cyc(1'b1, k == 0, 8'(k), "t6 pre");
        for (int k = 0; k < 14; k++) cyc(1'b1, k == 0, 8'(k + 30), "t6 part");
        #3;
        rst = 1'b1;
        #1;
        check_win("t6 reset window", dut_win(), 72'h0);
        check_bit("t6 reset win_vld", win_vld, 1'b0);
        check_bit("t6 reset frame_done", frame_done, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_idx = 0; m_last = '0; m_held = 1'b1;
        vld_seen = 0; fd_seen = 0;
        for (int k = 0; k < N; k++) cyc(1'b1, 1'b0, 8'(k + 60), "t6 restart");
        check_int("t6 strobe count", vld_seen, 6);
        check_int("t6 frame_done count", fd_seen, 1);
        gaps(3, "t6 tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
